// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter steering DEPTH requesters through a shared mux into one output register
// Optional packet lock (a granted requester keeps the mux until its last beat) enabled by defining MUX_RR_ARB_LOCK_EN.
module mux_rr_arbiter #(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 8,
    parameter int SEL_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DEPTH-1:0]           req_valid,
    input  logic [BIT_WIDTH*DEPTH-1:0] req_data,
    input  logic [DEPTH-1:0]           req_last,
    output logic [DEPTH-1:0]           req_ready,
    output logic                       out_valid,
    output logic [BIT_WIDTH-1:0]       out_data,
    output logic [SEL_WIDTH-1:0]       out_sel,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic [SEL_WIDTH-1:0] owner_q, owner_d;
    logic                 out_valid_q, out_valid_d;
    logic [BIT_WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0] out_sel_q, out_sel_d;
    logic                 out_last_q, out_last_d;

    logic                 load;
    logic                 grant_found;
    logic [SEL_WIDTH-1:0] grant_idx;
    logic                 in_xfer;
    logic [BIT_WIDTH-1:0] grant_lane;

    // Modular add that stays correct when DEPTH is not a power of two.
    function automatic logic [SEL_WIDTH-1:0] wrap_inc(input logic [SEL_WIDTH-1:0] base,
                                                       input int                   off);
        int sum;
        sum = int'(base) + off;
        if (sum >= DEPTH) begin
            sum = sum - DEPTH;
        end
        return sum[SEL_WIDTH-1:0];
    endfunction

    // Scan downward so the entry nearest ptr overwrites all later candidates.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        if (state_q == ST_LOCKED) begin
            grant_found = req_valid[owner_q];
            grant_idx   = owner_q;
        end else begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (req_valid[wrap_inc(ptr_q, k)]) begin
                    grant_found = 1'b1;
                    grant_idx   = wrap_inc(ptr_q, k);
                end
            end
        end
    end

    assign load       = !out_valid_q || out_ready;
    assign in_xfer    = grant_found && load && rst_n;
    assign grant_lane = req_data[BIT_WIDTH*grant_idx +: BIT_WIDTH];

    always_comb begin
        req_ready = '0;
        if (in_xfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_lane;
            out_sel_d   = grant_idx;
            out_last_d  = req_last[grant_idx];
`ifdef MUX_RR_ARB_LOCK_EN
            if (state_q == ST_IDLE && !req_last[grant_idx]) begin
                state_d = ST_LOCKED;
                owner_d = grant_idx;
            end else if (req_last[grant_idx]) begin
                state_d = ST_IDLE;
                ptr_d   = wrap_inc(grant_idx, 1);
            end
`else
            ptr_d = wrap_inc(grant_idx, 1);
`endif
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;
    assign busy      = out_valid_q || (state_q == ST_LOCKED);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter (DEPTH=8 and DEPTH=5 instances)
`timescale 1ns/1ps
module tb_mux_rr_arbiter;
    localparam int BW = 8;
    localparam int D  = 8;
    localparam int D5 = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [D-1:0]    req_valid, req_last, req_ready;
    logic [BW*D-1:0] req_data;
    logic            out_valid, out_last, out_ready, busy;
    logic [BW-1:0]   out_data;
    logic [2:0]      out_sel;

    logic [D5-1:0]    req_valid5, req_last5, req_ready5;
    logic [BW*D5-1:0] req_data5;
    logic             out_valid5, out_last5, out_ready5, busy5;
    logic [BW-1:0]    out_data5;
    logic [2:0]       out_sel5;

    int n_checks = 0;
    int n_fail   = 0;

    mux_rr_arbiter #(.BIT_WIDTH(BW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
        .out_ready(out_ready), .busy(busy)
    );

    mux_rr_arbiter #(.BIT_WIDTH(BW), .DEPTH(D5)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid5), .req_data(req_data5), .req_last(req_last5), .req_ready(req_ready5),
        .out_valid(out_valid5), .out_data(out_data5), .out_sel(out_sel5), .out_last(out_last5),
        .out_ready(out_ready5), .busy(busy5)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_valid  = '0; req_last  = '0; req_data  = '0; out_ready  = 1'b0;
        req_valid5 = '0; req_last5 = '0; req_data5 = '0; out_ready5 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        req_valid  = '1;
        req_valid5 = '1;
        out_ready  = 1'b1;
        out_ready5 = 1'b1;
        tick();
        n_checks++;
        if (req_ready !== 8'h00) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=00000000", req_ready); end
        n_checks++;
        if (req_ready5 !== 5'h00) begin n_fail++; $display("FAIL reset_req_ready5 got=%b exp=00000", req_ready5); end
        n_checks++;
        if ({out_valid, out_data, out_sel, out_last, busy} !== '0)
            begin n_fail++; $display("FAIL reset_outputs got v=%b d=%h s=%0d l=%b b=%b exp all zero",
                                     out_valid, out_data, out_sel, out_last, busy); end
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_all_valid();
        int e;
        do_reset();
        req_valid = '1;
        out_ready = 1'b1;
        for (int i = 0; i < D; i++) req_data[BW*i +: BW] = 8'(8'h10 + i);
        for (int n = 0; n < 9; n++) begin
            e = n % D;
            #1;
            n_checks++;
            if (req_ready !== 8'(1 << e)) begin n_fail++; $display("FAIL all_valid_ready n=%0d got=%b exp=%b", n, req_ready, 8'(1 << e)); end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 3'(e) || out_data !== 8'(8'h10 + e))
                begin n_fail++; $display("FAIL all_valid_out n=%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                                         n, out_valid, out_sel, out_data, e, 8'(8'h10 + e)); end
        end
    endtask

    task automatic test_ptr_start();
        int exp_sel[3];
        exp_sel = '{5, 2, 5};
        do_reset();
        out_ready = 1'b1;
        req_valid = 8'b0000_0111;
        req_last  = '1;
        tick(); tick(); tick();
        n_checks++;
        if (out_sel !== 3'd2) begin n_fail++; $display("FAIL ptr_setup got=%0d exp=2", out_sel); end
        req_valid = 8'b0010_0100;
        for (int n = 0; n < 3; n++) begin
            tick();
            n_checks++;
            if (out_sel !== 3'(exp_sel[n]) || out_valid !== 1'b1)
                begin n_fail++; $display("FAIL ptr_start n=%0d got=%0d exp=%0d", n, out_sel, exp_sel[n]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 8'b0000_0001;
        req_last  = 8'b0000_0001;
        req_data[0 +: BW] = 8'hA5;
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 8'b0000_0001) begin n_fail++; $display("FAIL bp_first_ready got=%b exp=00000001", req_ready); end
        tick();
        req_valid = 8'b0000_0100;
        req_data[2*BW +: BW] = 8'h3C;
        for (int n = 0; n < 4; n++) begin
            #1;
            n_checks++;
            if (req_ready !== 8'h00) begin n_fail++; $display("FAIL bp_hold_ready n=%0d got=%b exp=00000000", n, req_ready); end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 3'd0)
                begin n_fail++; $display("FAIL bp_hold_out n=%0d got v=%b d=%h s=%0d exp v=1 d=a5 s=0", n, out_valid, out_data, out_sel); end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 8'b0000_0100) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=00000100", req_ready); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 3'd2)
            begin n_fail++; $display("FAIL bp_release_out got v=%b d=%h s=%0d exp v=1 d=3c s=2", out_valid, out_data, out_sel); end
    endtask

    task automatic test_lock();
        int exp_sel[4];
        int b1;
`ifdef MUX_RR_ARB_LOCK_EN
        exp_sel = '{1, 1, 1, 0};
`else
        exp_sel = '{1, 0, 1, 0};
`endif
        do_reset();
        out_ready = 1'b1;
        req_valid = 8'b0000_0001;
        req_last  = 8'b0000_0001;
        req_data[0 +: BW] = 8'h0C;
        tick();
        b1 = 0;
        for (int n = 0; n < 4; n++) begin
            req_valid = {6'b0, (b1 < 3), 1'b1};
            req_last  = {6'b0, (b1 == 2), 1'b1};
            req_data[BW +: BW] = 8'(8'hB0 + b1);
            tick();
            n_checks++;
            if (out_sel !== 3'(exp_sel[n]) || out_data !== ((exp_sel[n] == 1) ? 8'(8'hB0 + b1) : 8'h0C))
                begin n_fail++; $display("FAIL lock_seq n=%0d got s=%0d d=%h exp s=%0d", n, out_sel, out_data, exp_sel[n]); end
            if (exp_sel[n] == 1) b1++;
        end
    endtask

    task automatic test_depth5();
        do_reset();
        req_valid5 = '1;
        out_ready5 = 1'b1;
        for (int i = 0; i < D5; i++) req_data5[BW*i +: BW] = 8'(8'h50 + i);
        for (int n = 0; n < 6; n++) begin
            tick();
            n_checks++;
            if (out_sel5 !== 3'(n % D5) || out_data5 !== 8'(8'h50 + n % D5) || out_valid5 !== 1'b1)
                begin n_fail++; $display("FAIL depth5 n=%0d got s=%0d d=%h exp s=%0d", n, out_sel5, out_data5, n % D5); end
        end
        req_valid5 = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        req_valid = 8'b0000_1000;
        req_last  = 8'b0000_0000;
        req_data[3*BW +: BW] = 8'h77;
        tick();
        n_checks++;
        if (busy !== 1'b1 || out_sel !== 3'd3) begin n_fail++; $display("FAIL rstmid_pre got b=%b s=%0d exp b=1 s=3", busy, out_sel); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 8'h00)
            begin n_fail++; $display("FAIL rstmid_async got v=%b b=%b r=%b exp v=0 b=0 r=0", out_valid, busy, req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 8'b0110_0100;
        req_last  = '1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'd2)
            begin n_fail++; $display("FAIL rstmid_first got v=%b s=%0d exp v=1 s=2", out_valid, out_sel); end
    endtask

    task automatic test_random();
        int ptr, owner, w, osel;
        bit locked, ov, olast, ld;
        logic [BW-1:0] odata;
        bit pv[D];
        bit pl[D];
        logic [BW-1:0] pd[D];
        logic [D-1:0] exp_rdy;
        ptr = 0; owner = 0; osel = 0; locked = 0; ov = 0; olast = 0; odata = '0;
        for (int i = 0; i < D; i++) begin pv[i] = 0; pl[i] = 0; pd[i] = '0; end
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            n_checks++;
            if (out_valid !== ov || busy !== (ov || locked) || out_data !== odata ||
                out_sel !== 3'(osel) || out_last !== olast)
                begin n_fail++; $display("FAIL rand_out cyc=%0d got v=%b b=%b d=%h s=%0d l=%b exp v=%b b=%b d=%h s=%0d l=%b",
                                         cyc, out_valid, busy, out_data, out_sel, out_last,
                                         ov, ov || locked, odata, osel, olast); end
            for (int i = 0; i < D; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    pv[i] = 1;
                    pd[i] = 8'($urandom);
                    pl[i] = ($urandom_range(0, 2) != 0);
                end
                req_valid[i] = pv[i];
                req_last[i]  = pl[i];
                req_data[BW*i +: BW] = pd[i];
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            w = -1;
            if (locked) begin
                if (pv[owner]) w = owner;
            end else begin
                for (int k = 0; k < D; k++)
                    if (w < 0 && pv[(ptr + k) % D]) w = (ptr + k) % D;
            end
            ld = !ov || out_ready;
            exp_rdy = (w >= 0 && ld) ? 8'(1 << w) : 8'h00;
            n_checks++;
            if (req_ready !== exp_rdy)
                begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy); end
            if (w >= 0 && ld) begin
                ov = 1; odata = pd[w]; osel = w; olast = pl[w]; pv[w] = 0;
`ifdef MUX_RR_ARB_LOCK_EN
                if (!locked && !pl[w]) begin
                    locked = 1; owner = w;
                end else if (pl[w]) begin
                    locked = 0; ptr = (w + 1) % D;
                end
`else
                ptr = (w + 1) % D;
`endif
            end else if (ov && out_ready) begin
                ov = 0;
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_all_valid();
        test_ptr_start();
        test_backpressure();
        test_lock();
        test_depth5();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
